// File: rtl/j1_stack.sv
// Parametrised J1 register-file stack driven by a signed stack delta, with pick port and depth count.
// Optional overflow/underflow guarding is compiled in with `define J1_STACK_GUARD_EN.
module j1_stack #(
   parameter  int WIDTH   = 16,
   parameter  int DEPTH   = 32,
   parameter  int DELTA_W = 2,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               en_i,
   input  logic [DELTA_W-1:0] delta_i,
   input  logic               we_i,
   input  logic [WIDTH-1:0]   wdata_i,
   output logic [WIDTH-1:0]   rd_data_o,
   input  logic [AW-1:0]      pick_i,
   output logic [WIDTH-1:0]   pick_data_o,
   output logic [AW:0]        depth_o,
   input  logic               clr_err_i,
   output logic               overflow_o,
   output logic               underflow_o
);

   logic [WIDTH-1:0]        mem_q [DEPTH];
   logic [AW:0]             cnt_q, cnt_d;
   logic                    ovf_q, ovf_d;
   logic                    unf_q, unf_d;
   logic signed [AW+1:0]    dext;
   logic signed [AW+1:0]    ncnt;
   logic [AW-1:0]           sp;
   logic [AW-1:0]           pick_addr;
   logic                    wr_en;

   assign sp        = cnt_q[AW-1:0];
   assign pick_addr = sp - pick_i;
   assign dext      = {{(AW+2-DELTA_W){delta_i[DELTA_W-1]}}, delta_i};
   assign ncnt      = $signed({1'b0, cnt_q}) + dext;

   always_comb begin
      cnt_d = cnt_q;
      wr_en = 1'b0;
`ifdef J1_STACK_GUARD_EN
      // A flag raised this cycle beats a simultaneous clear.
      ovf_d = ovf_q & ~clr_err_i;
      unf_d = unf_q & ~clr_err_i;
      if (en_i) begin
         if (ncnt > $signed((AW+2)'(DEPTH))) begin
            ovf_d = 1'b1;
         end else if (ncnt[AW+1]) begin
            unf_d = 1'b1;
         end else begin
            cnt_d = ncnt[AW:0];
            wr_en = we_i;
         end
      end
`else
      ovf_d = 1'b0;
      unf_d = 1'b0;
      if (en_i) begin
         cnt_d = {1'b0, ncnt[AW-1:0]};
         wr_en = we_i;
      end
`endif
   end

`ifndef J1_STACK_GUARD_EN
   // Circular build ignores the clear strobe and the count's upper bits.
   logic unused_bits;
   assign unused_bits = ^{clr_err_i, ncnt[AW+1:AW]};
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[ncnt[AW-1:0]] <= wdata_i;
   end

   assign rd_data_o   = mem_q[sp];
   assign pick_data_o = mem_q[pick_addr];
   assign depth_o     = cnt_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;

endmodule
